// File: rtl/rtc_pkg.sv
// Shared types and calendar constants for the RTC alarm slice.
package rtc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_RING   = 2'd2,
    ST_SNOOZE = 2'd3
  } alm_state_e;

  localparam int         SEC_PER_MIN   = 60;
  localparam int         HOURS_PER_DAY = 24;
  localparam logic [2:0] DOW_SUNDAY    = 3'd1;

endpackage

// File: rtl/rtc_hour_to24.sv
// Combinational 12h/24h hour normaliser, shared by the alarm and display paths.
module rtc_hour_to24
  import rtc_pkg::*;
(
  input  logic [5:0] hour_i,
  input  logic [1:0] mode_i,
  output logic [5:0] hour24_o
);

  localparam logic [5:0] HALF_DAY = 6'(HOURS_PER_DAY / 2);

  logic [5:0] base_12h;

  // In 12-hour form "12" is the first hour of its half-day.
  assign base_12h = (hour_i == HALF_DAY) ? 6'd0 : hour_i;
  assign hour24_o = mode_i[0] ? (base_12h + (mode_i[1] ? HALF_DAY : 6'd0)) : hour_i;

endmodule

// File: rtl/rtc_alarm.sv
// Day-of-week alarm with ring auto-stop, snooze and a sticky missed flag.
module rtc_alarm
  import rtc_pkg::*;
#(
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SEC   = 60
) (
  input  logic       clk_1Hz_i,
  input  logic       rstn_i,
  input  logic [5:0] cur_sec_i,
  input  logic [5:0] cur_min_i,
  input  logic [5:0] cur_hour_i,
  input  logic [1:0] cur_mode_i,
  input  logic [2:0] cur_day_of_week_i,
  input  logic       alm_wr_i,
  input  logic       alm_en_i,
  input  logic [5:0] alm_min_i,
  input  logic [4:0] alm_hour_i,
  input  logic [6:0] alm_dow_mask_i,
  input  logic       ack_i,
  input  logic       snooze_i,
  output logic       ring_o,
  output logic       irq_o,
  output logic       missed_o,
  output logic [1:0] state_o
);

  localparam logic [11:0] SNOOZE_LOAD = 12'(SNOOZE_MIN * SEC_PER_MIN - 1);
  localparam logic [6:0]  RING_LAST   = 7'(RING_SEC - 1);

  alm_state_e  state_q, state_d;
  logic [5:0]  alm_min_q, alm_min_d;
  logic [4:0]  alm_hour_q, alm_hour_d;
  logic [6:0]  alm_mask_q, alm_mask_d;
  logic [6:0]  ring_tmr_q, ring_tmr_d;
  logic [11:0] snz_cnt_q, snz_cnt_d;
  logic        irq_q, irq_d;
  logic        missed_q, missed_d;
  logic [5:0]  hour24;
  logic [2:0]  dow_idx;
  logic        match;

  rtc_hour_to24 u_hour_to24 (
    .hour_i   (cur_hour_i),
    .mode_i   (cur_mode_i),
    .hour24_o (hour24)
  );

  assign dow_idx = cur_day_of_week_i - DOW_SUNDAY;
  assign match   = (cur_sec_i == 6'd0) && (cur_min_i == alm_min_q) &&
                   (hour24 == {1'b0, alm_hour_q}) &&
                   (cur_day_of_week_i != 3'd0) && alm_mask_q[dow_idx];

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    state_d    = state_q;
    alm_min_d  = alm_min_q;
    alm_hour_d = alm_hour_q;
    alm_mask_d = alm_mask_q;
    ring_tmr_d = ring_tmr_q;
    snz_cnt_d  = snz_cnt_q;
    irq_d      = 1'b0;
    missed_d   = missed_q;

    if (alm_wr_i) begin
      alm_min_d  = alm_min_i;
      alm_hour_d = alm_hour_i;
      alm_mask_d = alm_dow_mask_i;
      state_d    = alm_en_i ? ST_ARMED : ST_IDLE;
      missed_d   = 1'b0;
      ring_tmr_d = '0;
      snz_cnt_d  = '0;
    end else begin
      if (ack_i && state_q != ST_IDLE) missed_d = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
        end
        ST_ARMED: begin
          // ack/snooze outrank a match even when they have nothing else to do.
          if (!ack_i && !snooze_i && match) begin
            state_d    = ST_RING;
            ring_tmr_d = '0;
            irq_d      = 1'b1;
          end
        end
        ST_RING: begin
          ring_tmr_d = ring_tmr_q + 7'd1;
          if (ack_i) begin
            state_d = ST_ARMED;
          end else if (snooze_i) begin
            state_d   = ST_SNOOZE;
            snz_cnt_d = SNOOZE_LOAD;
          end else if (ring_tmr_q == RING_LAST) begin
            state_d  = ST_ARMED;
            missed_d = 1'b1;
          end
        end
        ST_SNOOZE: begin
          snz_cnt_d = snz_cnt_q - 12'd1;
          if (ack_i) begin
            state_d = ST_ARMED;
          end else if (snz_cnt_q == 12'd0) begin
            state_d    = ST_RING;
            ring_tmr_d = '0;
            irq_d      = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_1Hz_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_IDLE;
      alm_min_q  <= '0;
      alm_hour_q <= '0;
      alm_mask_q <= '0;
      ring_tmr_q <= '0;
      snz_cnt_q  <= '0;
      irq_q      <= 1'b0;
      missed_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q    <= state_d;
      alm_min_q  <= alm_min_d;
      alm_hour_q <= alm_hour_d;
      alm_mask_q <= alm_mask_d;
      ring_tmr_q <= ring_tmr_d;
      snz_cnt_q  <= snz_cnt_d;
      irq_q      <= irq_d;
      missed_q   <= missed_d;
    end
  end

  assign ring_o   = (state_q == ST_RING);
  assign irq_o    = irq_q;
  assign missed_o = missed_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_rtc_alarm.sv
// Self-checking bench for rtc_alarm: directed scenarios plus random traffic against a timeline model.
module tb_rtc_alarm;

  localparam int SNOOZE_MIN = 1;
  localparam int RING_SEC   = 60;

  logic       clk_1Hz_i = 1'b0;
  logic       rstn_i;
  logic [5:0] cur_sec_i, cur_min_i, cur_hour_i;
  logic [1:0] cur_mode_i;
  logic [2:0] cur_day_of_week_i;
  logic       alm_wr_i, alm_en_i;
  logic [5:0] alm_min_i;
  logic [4:0] alm_hour_i;
  logic [6:0] alm_dow_mask_i;
  logic       ack_i, snooze_i;
  logic       ring_o, irq_o, missed_o;
  logic [1:0] state_o;

  int n_cmp = 0;
  int n_err = 0;

  rtc_alarm #(.SNOOZE_MIN(SNOOZE_MIN), .RING_SEC(RING_SEC)) dut (
    .clk_1Hz_i         (clk_1Hz_i),
    .rstn_i            (rstn_i),
    .cur_sec_i         (cur_sec_i),
    .cur_min_i         (cur_min_i),
    .cur_hour_i        (cur_hour_i),
    .cur_mode_i        (cur_mode_i),
    .cur_day_of_week_i (cur_day_of_week_i),
    .alm_wr_i          (alm_wr_i),
    .alm_en_i          (alm_en_i),
    .alm_min_i         (alm_min_i),
    .alm_hour_i        (alm_hour_i),
    .alm_dow_mask_i    (alm_dow_mask_i),
    .ack_i             (ack_i),
    .snooze_i          (snooze_i),
    .ring_o            (ring_o),
    .irq_o             (irq_o),
    .missed_o          (missed_o),
    .state_o           (state_o)
  );

  always #5 clk_1Hz_i = ~clk_1Hz_i;

  // Timeline model: 0 idle, 1 armed, 2 ringing, 3 snoozing; durations come from absolute cycle stamps.
  int         cyc;
  int         m_state;
  bit         m_irq, m_missed;
  int         m_ring_start, m_snz_start;
  int         m_amin, m_ahour;
  logic [6:0] m_mask;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_irq = 0; m_missed = 0;
    m_ring_start = 0; m_snz_start = 0;
    m_amin = 0; m_ahour = 0; m_mask = '0;
  endtask

  function automatic bit model_match();
    int h;
    int d;
    logic [6:0] mask;
    h = int'(cur_hour_i);
    if (cur_mode_i[0]) h = (h % 12) + (cur_mode_i[1] ? 12 : 0);
    d = int'(cur_day_of_week_i);
    mask = m_mask;
    if (d < 1 || d > 7) return 1'b0;
    return cur_sec_i == 6'd0 && int'(cur_min_i) == m_amin && h == m_ahour && mask[d-1];
  endfunction

  task automatic model_step();
    bit irq_n;
    irq_n = 1'b0;
    if (alm_wr_i) begin
      m_amin = int'(alm_min_i); m_ahour = int'(alm_hour_i); m_mask = alm_dow_mask_i;
      m_state = alm_en_i ? 1 : 0;
      m_missed = 1'b0;
    end else begin
      if (ack_i && m_state != 0) m_missed = 1'b0;
      case (m_state)
        1: if (!ack_i && !snooze_i && model_match()) begin
             m_state = 2; m_ring_start = cyc + 1; irq_n = 1'b1;
           end
        2: if (ack_i) m_state = 1;
           else if (snooze_i) begin m_state = 3; m_snz_start = cyc + 1; end
           else if (cyc - m_ring_start + 1 == RING_SEC) begin m_state = 1; m_missed = 1'b1; end
        3: if (ack_i) m_state = 1;
           else if (cyc - m_snz_start + 1 == SNOOZE_MIN * 60) begin
             m_state = 2; m_ring_start = cyc + 1; irq_n = 1'b1;
           end
        default: ;
      endcase
    end
    m_irq = irq_n;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_1Hz_i);
    #1;
    cyc++;
    check("ring", 32'(ring_o), 32'(m_state == 2));
    check("irq", 32'(irq_o), 32'(m_irq));
    check("missed", 32'(missed_o), 32'(m_missed));
    check("state", 32'(state_o), 32'(m_state));
  endtask

  task automatic set_time(input int h, input int m, input int s, input logic [1:0] mode, input int dow);
    cur_hour_i = 6'(h); cur_min_i = 6'(m); cur_sec_i = 6'(s);
    cur_mode_i = mode; cur_day_of_week_i = 3'(dow);
  endtask

  task automatic program_alarm(input bit en, input int h, input int m, input logic [6:0] mask);
    alm_wr_i = 1'b1; alm_en_i = en; alm_hour_i = 5'(h); alm_min_i = 6'(m); alm_dow_mask_i = mask;
    tick();
    alm_wr_i = 1'b0;
  endtask

  task automatic pulse_ack();
    ack_i = 1'b1;
    tick();
    ack_i = 1'b0;
  endtask

  initial begin
    int quiet;
    int rung;
    cyc = 0;
    model_reset();
    rstn_i = 1'b0;
    alm_wr_i = 0; alm_en_i = 0; alm_min_i = '0; alm_hour_i = '0; alm_dow_mask_i = '0;
    ack_i = 0; snooze_i = 0;
    set_time(0, 0, 1, 2'b00, 1);
    @(posedge clk_1Hz_i); #1;
    check("rst_ring", 32'(ring_o), 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    check("rst_missed", 32'(missed_o), 32'd0);
    check("rst_state", 32'(state_o), 32'd0);
    rstn_i = 1'b1;
    tick();

    // Basic 07:30 alarm on every day.
    program_alarm(1, 7, 30, 7'h7F);
    check("armed", 32'(state_o), 32'd1);
    set_time(7, 29, 59, 2'b00, 3); tick();
    check("pre_match_ring", 32'(ring_o), 32'd0);
    set_time(7, 30, 0, 2'b00, 3); tick();
    check("match_ring", 32'(ring_o), 32'd1);
    check("match_irq", 32'(irq_o), 32'd1);
    set_time(7, 30, 1, 2'b00, 3); tick();
    check("irq_one_cycle", 32'(irq_o), 32'd0);
    check("still_ring", 32'(ring_o), 32'd1);

    // ack and snooze together: ack wins.
    ack_i = 1; snooze_i = 1; tick(); ack_i = 0; snooze_i = 0;
    check("ack_snz_state", 32'(state_o), 32'd1);

    // Snooze then re-ring, then ring until auto-stop.
    set_time(7, 30, 0, 2'b00, 3); tick();
    check("rering", 32'(ring_o), 32'd1);
    set_time(7, 30, 1, 2'b00, 3);
    snooze_i = 1; tick(); snooze_i = 0;
    quiet = (ring_o === 1'b0) ? 1 : 0;
    while (ring_o === 1'b0 && quiet < 200) begin
      tick();
      if (ring_o === 1'b0) quiet++;
    end
    check("snooze_len", 32'(quiet), 32'd60);
    check("snooze_wake_irq", 32'(irq_o), 32'd1);
    rung = (ring_o === 1'b1) ? 1 : 0;
    while (ring_o === 1'b1 && rung < 200) begin
      tick();
      if (ring_o === 1'b1) rung++;
    end
    check("ring_len", 32'(rung), 32'(RING_SEC));
    check("autostop_state", 32'(state_o), 32'd1);
    check("autostop_missed", 32'(missed_o), 32'd1);
    pulse_ack();
    check("ack_clears_missed", 32'(missed_o), 32'd0);

    // 12-hour conversion cases.
    program_alarm(1, 0, 0, 7'h7F);
    set_time(12, 0, 0, 2'b01, 4); tick();
    check("h12_midnight", 32'(ring_o), 32'd1);
    pulse_ack();
    program_alarm(1, 19, 0, 7'h7F);
    set_time(7, 0, 0, 2'b11, 4); tick();
    check("h7pm", 32'(ring_o), 32'd1);
    set_time(7, 0, 1, 2'b11, 4);
    pulse_ack();
    set_time(7, 0, 0, 2'b01, 4); tick();
    check("h7am_no_ring", 32'(ring_o), 32'd0);

    // Write with en=0 coincident with a match.
    set_time(19, 0, 0, 2'b00, 4);
    program_alarm(0, 19, 0, 7'h7F);
    check("wr_idle_state", 32'(state_o), 32'd0);
    check("wr_no_irq", 32'(irq_o), 32'd0);
    tick();
    check("idle_ignores_match", 32'(ring_o), 32'd0);

    // Day mask and reset during RING.
    program_alarm(1, 8, 15, 7'h7E);
    set_time(8, 15, 0, 2'b00, 1); tick();
    check("mask_sunday_off", 32'(ring_o), 32'd0);
    set_time(8, 15, 0, 2'b00, 0); tick();
    check("dow0_no_ring", 32'(ring_o), 32'd0);
    set_time(8, 15, 0, 2'b00, 2); tick();
    check("mask_monday_on", 32'(ring_o), 32'd1);
    rstn_i = 1'b0;
    #1;
    check("async_rst_ring", 32'(ring_o), 32'd0);
    check("async_rst_state", 32'(state_o), 32'd0);
    check("async_rst_irq", 32'(irq_o), 32'd0);
    model_reset();
    @(posedge clk_1Hz_i); #1;
    rstn_i = 1'b1;
    tick();
    check("post_rst_irq", 32'(irq_o), 32'd0);

    // Random traffic.
    program_alarm(1, 6, 45, 7'h7F);
    for (int i = 0; i < 3000; i++) begin
      alm_wr_i = ($urandom_range(63) == 0);
      if (alm_wr_i) begin
        alm_en_i = ($urandom_range(3) != 0);
        alm_min_i = 6'($urandom_range(59));
        alm_hour_i = 5'($urandom_range(23));
        alm_dow_mask_i = 7'($urandom_range(127));
      end
      ack_i = ($urandom_range(24) == 0);
      snooze_i = ($urandom_range(15) == 0);
      if ($urandom_range(3) == 0) begin
        if ($urandom_range(1) == 1) begin
          set_time((m_ahour % 12 == 0) ? 12 : m_ahour % 12, m_amin, 0,
                   (m_ahour >= 12) ? 2'b11 : 2'b01, int'($urandom_range(7)));
        end else begin
          set_time(m_ahour, m_amin, 0, 2'b00, int'($urandom_range(7)));
        end
      end else begin
        set_time(int'($urandom_range(23)), int'($urandom_range(59)),
                 ($urandom_range(1) == 1) ? 0 : int'($urandom_range(59)), 2'b00,
                 int'($urandom_range(7)));
      end
      tick();
    end
    alm_wr_i = 0; ack_i = 0; snooze_i = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
